fgp_tx_scheduler: RTL
=====================

# fgp_tx_scheduler

Transmit-side sequencer for FGP (FPGA Graphics Protocol) packets. It walks the framebuffer in 512-color chunks and, for each chunk, negotiates a packet slot with the Ethernet TX path. It then streams the FGP payload on demand: offset byte, 127 zero padding bytes, and 768 data bytes read from the framebuffer RAM. It sits between the framebuffer read port and the encryption/Ethernet TX chain, and is the transmit counterpart of the FGP parser.

## Interface
- `NUM_CHUNKS`, 150: chunks per frame (1..256); chunk index is the offset byte.
- `ADDR_W`, 17: framebuffer byte-address width; must hold `NUM_CHUNKS*768-1`.
- `GAP_CYCLES`, 16: idle cycles between packets (0 allowed).
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: pulse; begin one frame when idle.
- `continuous` in 1: level; restart a new frame automatically after `frame_done`.
- `pkt_start` out 1: level; requests a TX slot, held until acknowledged.
- `pkt_ack` in 1: TX path accepts the packet; sampled only while `pkt_start`=1.
- `byte_req` in 1: pulse; TX path wants the next payload byte (any rate, up to every cycle).
- `outclk` out 1: pulse; `out` valid.
- `out` out 8: payload byte.
- `pkt_end` out 1: pulse coincident with `outclk` of byte 895 (last data byte).
- `ram_en` out 1: framebuffer read enable; RAM has 1-cycle registered read.
- `ram_addr` out ADDR_W: byte address `chunk*768 + data_cnt`.
- `ram_data` in 8: RAM read data, valid the cycle after `ram_en`.
- `busy` out 1: high in any state but IDLE.
- `frame_done` out 1: pulse after the last packet's gap completes.
- `dirty_set` in 1, `dirty_idx` in 8: only with `FGP_SCHED_DIRTY_EN`.

## Operation
- States: IDLE, REQ, OFFSET, PADDING, DATA, GAP. SCAN is added under the config macro.
- IDLE: on `start` or (`continuous` and `frame_done` last cycle), chunk←0, go to REQ.
- REQ: `pkt_start`=1; on `pkt_ack`, go to OFFSET with cnt←0. Ack in the same cycle `pkt_start` first rises is legal.
- OFFSET: 1 byte_req emits `chunk[7:0]`, then go to PADDING.
- PADDING: 127 byte_reqs emit 0x00, then go to DATA.
- DATA: 768 byte_reqs. Each asserts `ram_en` that cycle with `ram_addr`=chunk*768+cnt; the byte is forwarded from `ram_data`. After the 768th, go to GAP.
- GAP: count `GAP_CYCLES`, then advance the chunk. If chunk was `NUM_CHUNKS-1`, pulse `frame_done` and go to IDLE; otherwise go to REQ.
- `byte_req` in IDLE/REQ/GAP is ignored: no outclk, no RAM access.
- `start` while busy is ignored. Dropping `continuous` mid-frame finishes the current frame, then idles.
- Counter widths: cnt 10 bits, chunk 8 bits. `ram_addr` is computed as chunk*768 via shift-add (chunk<<9 + chunk<<8), no multiplier.

## Timing
- Byte latency is fixed at 2 cycles for every byte type: `byte_req` at cycle N → `outclk`/`out` at N+2. Offset/padding bytes pass through the same 2-stage pipe.
- Throughput: one byte per cycle sustained. Packet boundaries take effect on the request stream; in-flight bytes still drain after the state leaves DATA.
- `pkt_end` is asserted at N+2 for the 896th request.
- Reset values: `pkt_start`=0, `outclk`=0, `out`=0, `pkt_end`=0, `ram_en`=0, `ram_addr`=0, `busy`=0, `frame_done`=0, state=IDLE, and the pipe is flushed.
- Reset asserted mid-packet discards everything immediately; no partial `pkt_end` is produced.

## Configuration
- `FGP_SCHED_DIRTY_EN` defined:
  - Adds a `NUM_CHUNKS`-bit dirty bitmap; `dirty_set` sets `bitmap[dirty_idx]` (idx ≥ `NUM_CHUNKS` is ignored).
  - Frame start and post-GAP enter SCAN, which tests one chunk per cycle from the current index. A dirty chunk goes to REQ; reaching the end pulses `frame_done` and goes to IDLE.
  - A chunk's bit clears on `pkt_ack`. If a set and a clear hit the same bit in the same cycle, the set wins.
  - An all-clean frame completes in `NUM_CHUNKS` scan cycles with no packets.
- Not defined: no bitmap, no SCAN; every chunk is sent in order. `dirty_set`/`dirty_idx` ports are absent.

## Test plan
- NUM_CHUNKS=2, GAP_CYCLES=4, ack immediate, byte_req every cycle → per packet, 896 outclks: byte0=chunk, bytes1–127=0x00, bytes128–895=RAM[chunk*768+i]; `pkt_end` on byte 895; `frame_done` once, 4 cycles after the last GAP starts.
- byte_req every 4th cycle, ack delayed 10 cycles → each outclk exactly 2 cycles after its byte_req; `pkt_start` held all 10 cycles; no byte emitted before ack.
- byte_req pulses during REQ and GAP → no outclk, `ram_en` stays 0.
- `continuous`=1, dropped mid second frame → second frame completes fully, then IDLE; no third `pkt_start`.
- Assert `rst_n`=0 at data byte 300 → all outputs 0 asynchronously; a new `start` re-sends from chunk 0, offset 0x00.
- With `FGP_SCHED_DIRTY_EN`: dirty_set idx 1 only, start → exactly one packet with offset 0x01. Simultaneous set/clear of idx 1 → bit stays set and is resent on the next frame.

Source files
------------

// File: rtl/fgp_tx_scheduler.sv
// fgp_tx_scheduler
//   Transmit-side FGP packet sequencer. Walks the framebuffer one 512-color
//   (768-byte) chunk at a time. For each chunk it requests a TX slot, then
//   serves payload bytes on demand: offset byte (chunk index), 127 x 0x00
//   padding, 768 data bytes read from the framebuffer RAM. Every byte leaves
//   exactly 2 cycles after its byte_req.
//
//   Optional feature macro: FGP_SCHED_DIRTY_EN
//     Adds a per-chunk dirty bitmap and a SCAN state so that only dirty
//     chunks are sent. Adds ports dirty_set / dirty_idx.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   start, continuous    frame start pulse / auto-restart level
//   pkt_start, pkt_ack   TX slot request (held) / grant
//   byte_req             TX path pulls the next payload byte
//   outclk, out, pkt_end payload byte strobe, data, last-byte marker
//   ram_en, ram_addr,    framebuffer read port (1-cycle registered read)
//   ram_data
//   busy, frame_done     not-idle level / end-of-frame pulse
//   dirty_set, dirty_idx (macro only) mark a chunk dirty
module fgp_tx_scheduler #(
  parameter int NUM_CHUNKS = 150,
  parameter int ADDR_W     = 17,
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  output logic              pkt_start,
  input  logic              pkt_ack,
  input  logic              byte_req,
  output logic              outclk,
  output logic [7:0]        out,
  output logic              pkt_end,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
`ifdef FGP_SCHED_DIRTY_EN
  input  logic              dirty_set,
  input  logic [7:0]        dirty_idx,
`endif
  output logic              busy,
  output logic              frame_done
);

  localparam int          STAGES     = 2;
  localparam logic [9:0]  PAD_LAST   = 10'd126;
  localparam logic [9:0]  DATA_LAST  = 10'd767;
  localparam logic [7:0]  LAST_CHUNK = 8'(NUM_CHUNKS - 1);
  localparam logic [31:0] GAP_U      = 32'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_OFFSET, S_PADDING, S_DATA, S_GAP, S_SCAN
  } state_t;

`ifdef FGP_SCHED_DIRTY_EN
  localparam state_t S_NEXT = S_SCAN;
`else
  localparam state_t S_NEXT = S_REQ;
`endif

  // Stage-1 payload: what the byte will be once it reaches the output.
  typedef struct packed {
    logic       ram;   // take the byte from ram_data
    logic       last;  // final data byte of the packet
    logic [7:0] dat;   // offset / padding value
  } s1_t;

  state_t            state;
  logic [9:0]        cnt;
  logic [7:0]        chunk;
  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   vld_pipe;
  s1_t               s1;
  logic              acc;
  logic              gap_done;
  logic              last_chunk;
  logic              dirty_cur;

  // Requests count only while a packet is being served; elsewhere they drop.
  assign acc        = byte_req && (state == S_OFFSET || state == S_PADDING ||
                                   state == S_DATA);
  assign vld_pipe   = {vld_q, acc};
  assign outclk     = vld_pipe[STAGES];
  assign ram_en     = acc && (state == S_DATA);
  // chunk*768 = chunk*512 + chunk*256
  assign ram_addr   = ADDR_W'({chunk, 9'd0}) + ADDR_W'({chunk, 8'd0}) + ADDR_W'(cnt);
  assign pkt_start  = (state == S_REQ);
  assign busy       = (state != S_IDLE);
  assign last_chunk = (chunk == LAST_CHUNK);
  // GAP always lasts at least one cycle.
  assign gap_done   = (32'(cnt) + 32'd1) >= GAP_U;

`ifdef FGP_SCHED_DIRTY_EN
  logic [NUM_CHUNKS-1:0] dirty;
  logic [255:0]          dirty_ext;
  assign dirty_ext = 256'(dirty);
  assign dirty_cur = dirty_ext[chunk];

  // Clear on grant first, then set, so a same-cycle set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= '0;
    end else begin
      for (int i = 0; i < NUM_CHUNKS; i++) begin
        if (state == S_REQ && pkt_ack && chunk == 8'(i)) dirty[i] <= 1'b0;
        if (dirty_set && dirty_idx == 8'(i))            dirty[i] <= 1'b1;
      end
    end
  end
`else
  assign dirty_cur = 1'b1;
`endif

  // Sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      chunk      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (start || (continuous && frame_done)) begin
          chunk <= '0;
          cnt   <= '0;
          state <= S_NEXT;
        end
        S_REQ: if (pkt_ack) begin
          cnt   <= '0;
          state <= S_OFFSET;
        end
        S_OFFSET: if (byte_req) state <= S_PADDING;
        S_PADDING: if (byte_req) begin
          if (cnt == PAD_LAST) begin
            cnt   <= '0;
            state <= S_DATA;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        S_DATA: if (byte_req) begin
          if (cnt == DATA_LAST) begin
            cnt   <= '0;
            state <= S_GAP;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        S_GAP: begin
          if (gap_done) begin
            cnt <= '0;
            if (last_chunk) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              chunk <= chunk + 8'd1;
              state <= S_NEXT;
            end
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
`ifdef FGP_SCHED_DIRTY_EN
        S_SCAN: begin
          if (dirty_cur) begin
            state <= S_REQ;
          end else if (last_chunk) begin
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end else begin
            chunk <= chunk + 8'd1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // 2-stage byte pipe: stage 1 overlaps the RAM read, stage 2 drives out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      s1      <= '0;
      out     <= '0;
      pkt_end <= 1'b0;
    end else begin
      vld_q   <= vld_pipe[STAGES-1:0];
      s1.ram  <= (state == S_DATA);
      s1.last <= (state == S_DATA) && (cnt == DATA_LAST);
      s1.dat  <= (state == S_OFFSET) ? chunk : 8'h00;
      out     <= vld_pipe[1] ? (s1.ram ? ram_data : s1.dat) : 8'h00;
      pkt_end <= vld_pipe[1] && s1.last;
    end
  end

endmodule
